// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU read-out path.
//   DIM_DEF / WIDTH_DEF : default matrix dimension and element width
//   OP_*                : operation codes; OP_DET selects the single determinant beat
//   elem()              : bit offset of element k in the flat result bus
//   state_t             : read-out sequencer states
package mpu_pkg;

    localparam int DIM_DEF   = 5;
    localparam int WIDTH_DEF = 8;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_SCALE = 3'd2;
    localparam logic [2:0] OP_TRANS = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd4;
    localparam logic [2:0] OP_DET   = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Element k occupies result[elem(k) +: w].
    function automatic int elem(input int k, input int w = WIDTH_DEF);
        return w * k;
    endfunction

endpackage

// File: rtl/mpu_rowcol_counter.sv
// Row/column walker over an N x N window of the matrix.
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : restart at (0,0)
//   advance        : step one element (column first, wrapping into the next row)
//   n              : active dimension N
//   r_nxt, c_nxt   : position after this cycle's clear/advance is applied
//   last_nxt       : that position is the final element (N-1, N-1)
module mpu_rowcol_counter #(
    parameter int CW = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          advance,
    input  logic [CW-1:0] n,
    output logic [CW-1:0] r_nxt,
    output logic [CW-1:0] c_nxt,
    output logic          last_nxt
);

    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;
    logic [CW-1:0] n_m1;

    always_comb begin
        n_m1 = n - CW'(1);
        r_d  = r_q;
        c_d  = c_q;
        if (clear) begin
            r_d = '0;
            c_d = '0;
        end else if (advance) begin
            if (c_q == n_m1) begin
                c_d = '0;
                r_d = r_q + CW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end
        r_nxt    = r_d;
        c_nxt    = c_d;
        last_nxt = (r_d == n_m1) && (c_d == n_m1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

endmodule

// File: rtl/mpu_result_reader.sv
// Snapshots the MPU result matrix (or determinant) on start and streams the
// active N x N window row-major, one signed element per valid/ready beat.
//   clock, reset_n          : clock, asynchronous active-low reset
//   start                   : capture request, honoured only in IDLE
//   operation, size         : captured with the result; OP_DET gives one beat
//   result, determinant     : flat matrix (DIM stride) and determinant inputs
//   out_data/valid/ready/last : output stream
//   busy, done, error       : status; error is sticky until the next accepted start
module mpu_result_reader
    import mpu_pkg::*;
#(
    parameter int DIM   = DIM_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [2:0]               operation,
    input  logic [7:0]               size,
    input  logic [0:DIM*DIM*WIDTH-1] result,
    input  logic signed [WIDTH-1:0]  determinant,
    output logic signed [WIDTH-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int FLAT = DIM * DIM * WIDTH;
    localparam int CW   = $clog2(DIM) + 1;
    localparam int IW   = $clog2(FLAT);

    state_t                  state_q, state_d;
    logic [0:FLAT-1]         snap_q, snap_d;
    logic [2:0]              op_q, op_d;
    logic [CW-1:0]           n_q, n_d;
    logic signed [WIDTH-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic                    size_ok;
    logic                    hs;
    logic                    cnt_clear, cnt_adv, last_nxt;
    logic [CW-1:0]           cnt_n, r_nxt, c_nxt;
    logic [IW-1:0]           base;

    assign size_ok = (size != 8'd0) && (size <= 8'(DIM));
    assign hs      = valid_q && out_ready;
    // While idle the counter must see the incoming size so that a 1x1
    // transfer flags its first beat as last.
    assign cnt_n   = (state_q == IDLE) ? size[CW-1:0] : n_q;

    mpu_rowcol_counter #(.CW(CW)) u_rowcol (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (cnt_clear),
        .advance  (cnt_adv),
        .n        (cnt_n),
        .r_nxt    (r_nxt),
        .c_nxt    (c_nxt),
        .last_nxt (last_nxt)
    );

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        op_d      = op_q;
        n_d       = n_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        cnt_clear = 1'b0;
        cnt_adv   = 1'b0;
        // DIM stride: rows beyond the active window are skipped, not packed.
        base      = IW'(elem(int'(r_nxt) * DIM + int'(c_nxt), WIDTH));

        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = result;
                    op_d    = operation;
                    n_d     = size[CW-1:0];
                    error_d = !size_ok;
                    if (!size_ok) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = STREAM;
                        busy_d    = 1'b1;
                        valid_d   = 1'b1;
                        cnt_clear = 1'b1;
                        // First beat comes straight from the inputs since the
                        // snapshot is only loaded on this same edge.
                        if (operation == OP_DET) begin
                            data_d = determinant;
                            last_d = 1'b1;
                        end else begin
                            data_d = result[0 +: WIDTH];
                            last_d = last_nxt;
                        end
                    end
                end
            end
            STREAM: begin
                if (hs) begin
                    if (last_q) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_adv = 1'b1;
                        data_d  = snap_q[base +: WIDTH];
                        last_d  = last_nxt || (op_q == OP_DET);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            op_q    <= '0;
            n_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            op_q    <= op_d;
            n_q     <= n_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_mpu_result_reader.sv
// Bench for mpu_result_reader: random matrices streamed under several ready
// patterns, compared against a row-major beat list built from the matrix.
module tb_mpu_result_reader;

    localparam int DIM  = 5;
    localparam int W    = 8;
    localparam int FLAT = DIM * DIM * W;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  start = 1'b0;
    logic [2:0]            operation = 3'd0;
    logic [7:0]            size = 8'd0;
    logic [0:FLAT-1]       result = '0;
    logic signed [W-1:0]   determinant = '0;
    logic signed [W-1:0]   out_data;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic                  error;

    int n_assert = 0;
    int n_fail   = 0;

    logic signed [W-1:0] mat [DIM*DIM];
    logic signed [W-1:0] exp_q [$];
    logic signed [W-1:0] got_d [$];
    logic                got_l [$];

    mpu_result_reader dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .operation   (operation),
        .size        (size),
        .result      (result),
        .determinant (determinant),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_mat();
        for (int k = 0; k < DIM*DIM; k++) mat[k] = W'($urandom());
    endtask

    task automatic pack();
        for (int k = 0; k < DIM*DIM; k++) result[k*W +: W] = mat[k];
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic xfer(input int sz, input int op, input int mode, input bit midchange,
                        input string tag);
        bit                  ok;
        bit                  got_done;
        bit                  stalled;
        bit                  rdy;
        logic signed [W-1:0] held;
        ok = (sz >= 1) && (sz <= DIM);
        exp_q.delete();
        got_d.delete();
        got_l.delete();
        if (ok) begin
            if (op == 5) exp_q.push_back(determinant);
            else
                for (int r = 0; r < sz; r++)
                    for (int c = 0; c < sz; c++) exp_q.push_back(mat[r*DIM + c]);
        end

        @(negedge clock);
        start     = 1'b1;
        size      = 8'(sz);
        operation = 3'(op);
        @(negedge clock);
        start = 1'b0;
        chk({tag, "_busy_rise"},  32'(busy),      32'(ok));
        chk({tag, "_valid_rise"}, 32'(out_valid), 32'(ok));
        chk({tag, "_error_cap"},  32'(error),     32'(!ok));

        got_done = 1'b0;
        stalled  = 1'b0;
        held     = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (stalled && out_valid) chk({tag, "_hold"}, 32'(out_data), 32'(held));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (out_valid && rdy) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
            end
            stalled = out_valid && !rdy;
            held    = out_data;
            if (midchange && cyc == 2) begin
                rand_mat();
                pack();
                start     = 1'b1;
                size      = 8'd2;
                operation = 3'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        start     = 1'b0;
        out_ready = 1'b0;

        chk({tag, "_done_seen"},  32'(got_done),  32'd1);
        chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_done_busy"},  32'(busy),      32'd0);
        chk({tag, "_error"},      32'(error),     32'(!ok));
        chk({tag, "_beats"},      32'(got_d.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), 32'(got_d[i]), 32'(exp_q[i]));
            chk($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(i == exp_q.size() - 1));
        end
        @(negedge clock);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        rand_mat();
        pack();

        // Reset values
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_error", 32'(error),     32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Abort mid-stream after three accepted beats of a 3x3 transfer
        @(negedge clock);
        start     = 1'b1;
        size      = 8'd3;
        operation = 3'd0;
        @(negedge clock);
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("abort_beat3", 32'(out_data), 32'(mat[DIM]));
        reset_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy",  32'(busy),      32'd0);
        chk("abort_done",  32'(done),      32'd0);
        chk("abort_last",  32'(out_last),  32'd0);
        out_ready = 1'b0;
        @(negedge clock);
        chk("abort_nodone", 32'(done), 32'd0);
        reset_n = 1'b1;

        // 2x2 directed: elements 0,1,5,6
        rand_mat();
        mat[0] = 8'sd1;
        mat[1] = 8'sd2;
        mat[5] = -8'sd3;
        mat[6] = 8'sd4;
        pack();
        xfer(2, 0, 0, 1'b0, "s2x2");

        // 3x3 with backpressure
        rand_mat();
        pack();
        xfer(3, 4, 1, 1'b0, "bp3x3");

        // Determinant beat
        determinant = -8'sd7;
        xfer(3, 5, 0, 1'b0, "det");

        // Size bounds, then a full 5x5 that clears the error
        xfer(0, 0, 0, 1'b0, "size0");
        xfer(6, 1, 0, 1'b0, "size6");
        rand_mat();
        pack();
        xfer(5, 2, 2, 1'b0, "full5");

        // start with new inputs during STREAM is ignored
        rand_mat();
        pack();
        xfer(4, 1, 0, 1'b1, "midstart");

        // 1x1 edge and random mix
        rand_mat();
        pack();
        xfer(1, 3, 1, 1'b0, "one");
        for (int t = 0; t < 6; t++) begin
            rand_mat();
            pack();
            determinant = W'($urandom());
            xfer(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)), 2, 1'b0,
                 $sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
